wait_state_memory: RTL and testbench
====================================

# wait_state_memory

Parametrised, clocked successor to the team's combinational 256x16 memory model. Serves one CPU-side master over the same request / rw / wait_ handshake, but is configurable in width, depth and access latency, with registered read data, an abortable transaction, and an address-range error flag. It sits between the CPU bus interface and main memory, and it is the memory model for all multi-cycle CPU benches.

## Interface
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 16, bus address width
- DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH
- WAIT_CYCLES, 2, wait states inserted per access; 0 is legal

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- addrs_bus  in  ADDR_WIDTH  word address
- request  in  1  master requests an access; level-held
- rw  in  1  1 = read, 0 = write
- data_bus_write  in  DATA_WIDTH  write data
- wait_  out  1  1 = access in progress, master must hold request
- data_bus_read  out  DATA_WIDTH  registered read data
- addr_err  out  1  last completed access was out of range

## Operation
- Storage: DEPTH x DATA_WIDTH array, zero-initialised at simulation start. Reset does not clear storage.
- FSM states:
  - IDLE: when request=1, latch addr, rw and wdata. Go to WAIT with cnt=WAIT_CYCLES-1, or go straight to DONE if WAIT_CYCLES=0.
  - WAIT: if request=0, abort and go to IDLE with no write. Else if cnt=0, perform the access and go to DONE. Else cnt--.
  - DONE: always go to IDLE at the next edge.
- Access is performed on the edge that enters DONE:
  - write: mem[addr] <= latched wdata
  - read: data_bus_read <= mem[addr]
  - addr_err <= (addr ≥ DEPTH)
- Out-of-range address: the write is dropped; a read loads 0 into data_bus_read. addr_err=1 and holds until the next completed access.
- wait_ = request && (state != DONE). This is combinational, so wait_ rises in the same cycle the request appears.
- Transaction fields are taken from the latched copies, not from the live bus. Changing addr/rw/data mid-access has no effect.
- data_bus_read holds its value across writes, aborts and idle cycles.

## Timing
- Reset values: state=IDLE, cnt=0, data_bus_read=0, addr_err=0. wait_ therefore equals request while in IDLE.
- Latency: request first sampled at edge E0. DONE is entered at edge E(WAIT_CYCLES), and wait_ falls right after it (WAIT_CYCLES+1 edges).
- The master treats request=1 && wait_=0 as completion. data_bus_read is valid in that cycle and afterwards.
- If request is still high in the cycle after DONE, the block accepts a new transaction in IDLE. Throughput is one access per WAIT_CYCLES+2 cycles.
- Aborts:
  - request low during WAIT: abort on that edge, no storage or output change.
  - request low during DONE: the access has already completed.
- reset_n asserted mid-transaction: immediate return to IDLE and outputs reset. A write not yet committed is lost; one already committed persists.
- The counter is $clog2(WAIT_CYCLES+1) bits wide, minimum 1.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, WAIT, DONE)
  - default parameter constants
  - the rw encoding constants RW_READ=1, RW_WRITE=0
- Sub-module sync_ram_array: a DEPTH x DATA_WIDTH array with a single synchronous write port and a single synchronous read port, plus a range check. Control and the FSM live in wait_state_memory.

## Test plan
- Reset, then preload mem[4]=16'habcd. Read addr 4 with WAIT_CYCLES=2 → wait_ high for 3 cycles, then data_bus_read=16'habcd, addr_err=0.
- Write 16'h1234 to addr 8, then read addr 8 → 16'h1234. Reading addr 9 → 0.
- WAIT_CYCLES=0 build: read completes one edge after the request. Back-to-back held requests complete every 2 cycles.
- Drop request during WAIT of a write of 16'hffff to addr 3 → mem[3] stays 0, data_bus_read unchanged, FSM back in IDLE.
- Read addr 300 with DEPTH=256 → data_bus_read=0, addr_err=1. A subsequent valid read clears addr_err.
- Assert reset_n low during WAIT → data_bus_read=0 and state IDLE at once. A later read of the target address returns its old value.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the wait-state memory model:
//   - default parameter values (width, address width, depth, wait states)
//   - rw bus encoding (RW_READ / RW_WRITE)
//   - transaction FSM state type
//   - width helpers for the wait counter and the storage index
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_CYCLES = 2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold WAIT_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

    // Bits needed to index DEPTH words; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_ram_array.sv
// ---------------------------------------------------------------------------
// sync_ram_array
// DEPTH x DATA_WIDTH storage with one synchronous write port, one
// synchronous (registered) read port and an address range check.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (read register only)
//   en_i       in   perform an access on this edge
//   rw_i       in   RW_READ / RW_WRITE
//   addr_i     in   word address (full bus width)
//   wdata_i    in   write data
//   rdata_o    out  registered read data; holds across writes and idle
//   in_range_o out  combinational: addr_i < DEPTH
// ---------------------------------------------------------------------------
module sync_ram_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  rw_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  in_range_o
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      idx;

    // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
    assign in_range_o = ({1'b0, addr_i} < (ADDR_WIDTH + 1)'(DEPTH));
    assign idx        = addr_i[IDX_W-1:0];

    // NOTE: storage has no reset; it powers up as zero in simulation and
    // must survive reset_n so committed writes persist.
    always_ff @(posedge clk) begin
        if (en_i && (rw_i == RW_WRITE) && in_range_o) begin
            mem_q[idx] <= wdata_i;
        end
    end

    // Out-of-range reads return zero rather than aliasing into the array.
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && (rw_i == RW_READ)) begin
            rdata_q <= in_range_o ? mem_q[idx] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wait_state_memory.sv
// ---------------------------------------------------------------------------
// wait_state_memory
// Clocked CPU-side memory model with a configurable number of wait states,
// registered read data, abortable transactions and an address-range flag.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   addrs_bus      in   word address
//   request        in   master requests an access (level-held)
//   rw             in   1 = read, 0 = write
//   data_bus_write in   write data
//   wait_          out  1 while the access is in progress
//   data_bus_read  out  registered read data
//   addr_err       out  last completed access was out of range
// ---------------------------------------------------------------------------
module wait_state_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] addrs_bus,
    input  logic                  request,
    input  logic                  rw,
    input  logic [DATA_WIDTH-1:0] data_bus_write,
    output logic                  wait_,
    output logic [DATA_WIDTH-1:0] data_bus_read,
    output logic                  addr_err
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  addr_err_q;

    // Access port into the array, valid on the edge that enters DONE.
    logic                  access;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_rw;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rw_q       <= RW_READ;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            if (access) begin
                addr_err_q <= !acc_in_range;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        access    = 1'b0;
        acc_addr  = addr_q;
        acc_rw    = rw_q;
        acc_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (request) begin
                    addr_d  = addrs_bus;
                    rw_d    = rw;
                    wdata_d = data_bus_write;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access happens on the very
                        // edge that samples the request, so use the live bus.
                        state_d   = DONE;
                        access    = 1'b1;
                        acc_addr  = addrs_bus;
                        acc_rw    = rw;
                        acc_wdata = data_bus_write;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!request) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    sync_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk        (clk),
        .rst_n      (reset_n),
        .en_i       (access),
        .rw_i       (acc_rw),
        .addr_i     (acc_addr),
        .wdata_i    (acc_wdata),
        .rdata_o    (data_bus_read),
        .in_range_o (acc_in_range)
    );

    // Combinational so the master sees wait_ in the same cycle it raises
    // request; it drops only during the single DONE cycle.
    assign wait_    = request && (state_q != DONE);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// ---------------------------------------------------------------------------
// tb_wait_state_memory
// Two instances share one clock and reset: inst 0 has WAIT_CYCLES=2,
// inst 1 has WAIT_CYCLES=0. A transaction-level model (start edge,
// completion edge, next-accept edge, associative-array storage) predicts
// wait_, data_bus_read and addr_err, compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_wait_state_memory;
    import mem_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req  [2];
    logic          rws  [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd   [2];
    logic          wt   [2];
    logic [DW-1:0] rd   [2];
    logic          er   [2];

    int checks;
    int errors;

    always #5 clk = ~clk;

    wait_state_memory #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEPTH), .WAIT_CYCLES (2)
    ) dut_w2 (
        .clk            (clk),
        .reset_n        (reset_n),
        .addrs_bus      (addr[0]),
        .request        (req[0]),
        .rw             (rws[0]),
        .data_bus_write (wd[0]),
        .wait_          (wt[0]),
        .data_bus_read  (rd[0]),
        .addr_err       (er[0])
    );

    wait_state_memory #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEPTH), .WAIT_CYCLES (0)
    ) dut_w0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .addrs_bus      (addr[1]),
        .request        (req[1]),
        .rw             (rws[1]),
        .data_bus_write (wd[1]),
        .wait_          (wt[1]),
        .data_bus_read  (rd[1]),
        .addr_err       (er[1])
    );

    // ---------------- behavioural model ----------------
    function automatic int wc_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    logic [DW-1:0] m_mem [int];     // key = inst*65536 + addr; absent = 0
    int            ecount;          // rising edges seen outside reset
    bit            m_pend      [2];
    int            m_start     [2];
    int            m_done_edge [2];
    int            m_next_free [2];
    logic [AW-1:0] m_addr      [2];
    bit            m_rw        [2];
    logic [DW-1:0] m_wd        [2];
    logic [DW-1:0] m_rd        [2];
    bit            m_err       [2];

    task automatic m_complete(input int i, input int n);
        int key;
        key = i * 65536 + int'(m_addr[i]);
        if (int'(m_addr[i]) < DEPTH) begin
            if (m_rw[i]) m_rd[i] = m_mem.exists(key) ? m_mem[key] : '0;
            else         m_mem[key] = m_wd[i];
            m_err[i] = 1'b0;
        end else begin
            if (m_rw[i]) m_rd[i] = '0;
            m_err[i] = 1'b1;
        end
        m_pend[i]      = 1'b0;
        m_done_edge[i] = n;
        m_next_free[i] = n + 2;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i]      = 1'b0;
                m_rd[i]        = '0;
                m_err[i]       = 1'b0;
                m_done_edge[i] = -10;
                m_next_free[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i]) begin
                    if (!req[i]) m_pend[i] = 1'b0;
                    else if (ecount == m_start[i] + wc_of(i)) m_complete(i, ecount);
                end else if (req[i] && ecount >= m_next_free[i]) begin
                    m_pend[i]  = 1'b1;
                    m_start[i] = ecount;
                    m_addr[i]  = addr[i];
                    m_rw[i]    = rws[i];
                    m_wd[i]    = wd[i];
                    if (wc_of(i) == 0) m_complete(i, ecount);
                end
            end
            ecount++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wait_[%0d]", i), 32'(wt[i]),
                  32'(req[i] && (m_done_edge[i] != ecount - 1)));
            check($sformatf("data_bus_read[%0d]", i), 32'(rd[i]), 32'(m_rd[i]));
            check($sformatf("addr_err[%0d]", i), 32'(er[i]), 32'(m_err[i]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    // Full master transaction; returns the number of cycles wait_ was high.
    task automatic access(input int i, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit scramble, output int wcnt);
        bit done;
        done    = 1'b0;
        req[i]  = 1'b1;
        rws[i]  = r;
        addr[i] = a;
        wd[i]   = d;
        #1;
        wcnt = wt[i] ? 1 : 0;
        for (int k = 0; k < 16 && !done; k++) begin
            tick();
            if (!wt[i]) begin
                done = 1'b1;
            end else begin
                wcnt++;
                if (scramble) begin
                    addr[i] = AW'($urandom);
                    rws[i]  = ~r;
                    wd[i]   = DW'($urandom);
                end
            end
        end
        check($sformatf("timeout[%0d]", i), 32'(done), 32'd1);
        req[i] = 1'b0;
        tick();
    endtask

    initial begin
        int w;
        int completions;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; rws[i] = RW_READ; addr[i] = '0; wd[i] = '0;
        end
        repeat (3) tick();
        check("reset_rd0", 32'(rd[0]), 32'h0);
        check("reset_err0", 32'(er[0]), 32'h0);
        check("reset_rd1", 32'(rd[1]), 32'h0);
        reset_n = 1'b1;
        tick();

        // Preload and read back with two wait states.
        access(0, RW_WRITE, 16'd4, 16'habcd, 1'b0, w);
        access(0, RW_READ, 16'd4, 16'h0, 1'b0, w);
        check("read4_wait_cycles", 32'(w), 32'd3);
        check("read4_data", 32'(rd[0]), 32'habcd);
        check("read4_err", 32'(er[0]), 32'h0);

        // Write/read with the bus scrambled mid-access; untouched word is 0.
        access(0, RW_WRITE, 16'd8, 16'h1234, 1'b1, w);
        access(0, RW_READ, 16'd9, 16'h0, 1'b0, w);
        check("read9_zero", 32'(rd[0]), 32'h0);
        access(0, RW_READ, 16'd8, 16'h0, 1'b1, w);
        check("read8_data", 32'(rd[0]), 32'h1234);

        // Abort a write on the last WAIT edge.
        req[0] = 1'b1; rws[0] = RW_WRITE; addr[0] = 16'd3; wd[0] = 16'hffff;
        tick();
        tick();
        check("abort_in_progress", 32'(wt[0]), 32'd1);
        req[0] = 1'b0;
        tick();
        tick();
        check("abort_rd_held", 32'(rd[0]), 32'h1234);
        access(0, RW_READ, 16'd3, 16'h0, 1'b0, w);
        check("abort_fresh_latency", 32'(w), 32'd3);
        check("abort_no_write", 32'(rd[0]), 32'h0);

        // Out-of-range read, dropped write, then a valid read clears the flag.
        access(0, RW_READ, 16'd300, 16'h0, 1'b0, w);
        check("oor_read_data", 32'(rd[0]), 32'h0);
        check("oor_read_err", 32'(er[0]), 32'd1);
        access(0, RW_WRITE, 16'd300, 16'hbeef, 1'b0, w);
        check("oor_write_err", 32'(er[0]), 32'd1);
        access(0, RW_READ, 16'd4, 16'h0, 1'b0, w);
        check("recover_data", 32'(rd[0]), 32'habcd);
        check("recover_err", 32'(er[0]), 32'h0);

        // Reset during WAIT of a write: outputs clear at once, write is lost.
        req[0] = 1'b1; rws[0] = RW_WRITE; addr[0] = 16'd8; wd[0] = 16'h5555;
        tick();
        reset_n = 1'b0;
        #1;
        check("midreset_rd", 32'(rd[0]), 32'h0);
        req[0] = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        access(0, RW_READ, 16'd8, 16'h0, 1'b0, w);
        check("midreset_write_lost", 32'(rd[0]), 32'h1234);

        // Zero wait states.
        access(1, RW_WRITE, 16'd5, 16'h0077, 1'b0, w);
        check("w0_write_wait", 32'(w), 32'd1);
        access(1, RW_READ, 16'd5, 16'h0, 1'b0, w);
        check("w0_read_wait", 32'(w), 32'd1);
        check("w0_read_data", 32'(rd[1]), 32'h0077);
        req[1] = 1'b1; rws[1] = RW_READ; addr[1] = 16'd5;
        completions = 0;
        repeat (8) begin
            tick();
            if (!wt[1]) completions++;
        end
        req[1] = 1'b0;
        tick();
        check("w0_back_to_back", 32'(completions), 32'd4);

        // Randomized traffic on both instances with occasional resets.
        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                req[i]  = ($urandom_range(0, 7) != 0);
                rws[i]  = 1'($urandom_range(0, 1));
                addr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(250, 300))
                                                      : AW'($urandom_range(0, 15));
                wd[i]   = DW'($urandom);
            end
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
        end
        for (int i = 0; i < 2; i++) req[i] = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
